// File: rtl/cpu_pkg.sv
// Shared control-bundle types, ALU class encodings and stage helpers for the
// hazard/control pipeline (optional stall counter: HAZARD_CNT_EN).
package cpu_pkg;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_BR  = 2'b01;
  localparam logic [1:0] ALU_R   = 2'b10;
  localparam logic [1:0] ALU_I   = 2'b11;

  typedef struct packed {
    logic       reg_write;
    logic       memto_reg;
    logic       mem_read;
    logic       mem_write;
    logic       alu_src;
    logic [1:0] alu_op;
    logic [4:0] rd;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = ctrl_t'(12'h000);

  // EX/MEM no longer needs the ALU controls.
  function automatic ctrl_t to_mem(input ctrl_t c);
    ctrl_t m;
    m         = c;
    m.alu_src = 1'b0;
    m.alu_op  = ALU_ADD;
    return m;
  endfunction

  // MEM/WB keeps only the write-back controls and rd.
  function automatic ctrl_t to_wb(input ctrl_t c);
    ctrl_t w;
    w           = CTRL_BUBBLE;
    w.reg_write = c.reg_write;
    w.memto_reg = c.memto_reg;
    w.rd        = c.rd;
    return w;
  endfunction

endpackage

// File: rtl/ctrl_stage_reg.sv
// One pipeline stage of the control bundle: sync reset, hold and bubble-load.
module ctrl_stage_reg
  import cpu_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  hold,
  input  logic  bubble,
  input  ctrl_t d,
  output ctrl_t q
);

  // Reset beats hold, hold beats bubble, bubble beats the normal load.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= CTRL_BUBBLE;
    end else if (hold) begin
      q <= q;
    end else if (bubble) begin
      q <= CTRL_BUBBLE;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/ctrl_hazard_pipe.sv
// ID/EX, EX/MEM, MEM/WB control pipeline with load-use hazard detection.
// Define HAZARD_CNT_EN to add the saturating stall_cnt_o counter.
module ctrl_hazard_pipe
  import cpu_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       RegWrite_i,
  input  logic       MemtoReg_i,
  input  logic       MemRead_i,
  input  logic       MemWrite_i,
  input  logic       ALUSrc_i,
  input  logic [1:0] ALUOp_i,
  input  logic [4:0] rs1_i,
  input  logic [4:0] rs2_i,
  input  logic [4:0] rd_i,
  input  logic       stall_i,
  input  logic       flush_i,
  output logic       NoOp_o,
  output logic       Stall_o,
  output logic [1:0] ALUOp_ex_o,
  output logic       ALUSrc_ex_o,
  output logic       MemRead_ex_o,
  output logic [4:0] rd_ex_o,
  output logic       MemRead_mem_o,
  output logic       MemWrite_mem_o,
  output logic       RegWrite_mem_o,
  output logic [4:0] rd_mem_o,
  output logic       RegWrite_wb_o,
  output logic       MemtoReg_wb_o,
  output logic [4:0] rd_wb_o
`ifdef HAZARD_CNT_EN
  ,
  output logic [15:0] stall_cnt_o
`endif
);

  ctrl_t id_c;
  ctrl_t ex_q;
  ctrl_t mem_q;
  ctrl_t wb_q;
  logic  hazard;
  logic  unused_bits;

  assign id_c = '{reg_write: RegWrite_i, memto_reg: MemtoReg_i, mem_read: MemRead_i,
                  mem_write: MemWrite_i, alu_src: ALUSrc_i, alu_op: ALUOp_i, rd: rd_i};

  // rs2 is compared for every opcode; a spurious stall is cheaper than decoding it.
  assign hazard = ex_q.mem_read && (ex_q.rd != 5'd0) &&
                  ((ex_q.rd == rs1_i) || (ex_q.rd == rs2_i));

  ctrl_stage_reg u_id_ex (
    .clk(clk_i), .rst(rst_i), .hold(stall_i), .bubble(flush_i | hazard),
    .d(id_c), .q(ex_q)
  );

  ctrl_stage_reg u_ex_mem (
    .clk(clk_i), .rst(rst_i), .hold(stall_i), .bubble(1'b0),
    .d(to_mem(ex_q)), .q(mem_q)
  );

  ctrl_stage_reg u_mem_wb (
    .clk(clk_i), .rst(rst_i), .hold(stall_i), .bubble(1'b0),
    .d(to_wb(mem_q)), .q(wb_q)
  );

  assign NoOp_o         = hazard;
  assign Stall_o        = hazard;
  assign ALUOp_ex_o     = ex_q.alu_op;
  assign ALUSrc_ex_o    = ex_q.alu_src;
  assign MemRead_ex_o   = ex_q.mem_read;
  assign rd_ex_o        = ex_q.rd;
  assign MemRead_mem_o  = mem_q.mem_read;
  assign MemWrite_mem_o = mem_q.mem_write;
  assign RegWrite_mem_o = mem_q.reg_write;
  assign rd_mem_o       = mem_q.rd;
  assign RegWrite_wb_o  = wb_q.reg_write;
  assign MemtoReg_wb_o  = wb_q.memto_reg;
  assign rd_wb_o        = wb_q.rd;

  assign unused_bits = ^{mem_q.alu_src, mem_q.alu_op, wb_q.mem_read, wb_q.mem_write,
                         wb_q.alu_src, wb_q.alu_op, ALU_BR, ALU_R, ALU_I};

`ifdef HAZARD_CNT_EN
  logic [15:0] stall_cnt_r;

  // Counts cycles where a load-use bubble is actually inserted; saturates.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_r <= 16'h0000;
    end else if (hazard && !stall_i && (stall_cnt_r != 16'hFFFF)) begin
      stall_cnt_r <= stall_cnt_r + 16'h0001;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign stall_cnt_o = stall_cnt_r;
`endif

endmodule

// File: tb/tb_ctrl_hazard_pipe.sv
// Scoreboard bench for ctrl_hazard_pipe; counter checks compile in with HAZARD_CNT_EN.
module tb_ctrl_hazard_pipe;

  typedef struct packed {
    logic       rw;
    logic       m2r;
    logic       mrd;
    logic       mwr;
    logic       asrc;
    logic [1:0] aop;
    logic [4:0] rd;
  } ins_t;

  logic       clk = 1'b0;
  logic       rst_i, RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i, ALUSrc_i;
  logic [1:0] ALUOp_i;
  logic [4:0] rs1_i, rs2_i, rd_i;
  logic       stall_i, flush_i;
  logic       NoOp_o, Stall_o;
  logic [1:0] ALUOp_ex_o;
  logic       ALUSrc_ex_o, MemRead_ex_o;
  logic [4:0] rd_ex_o;
  logic       MemRead_mem_o, MemWrite_mem_o, RegWrite_mem_o;
  logic [4:0] rd_mem_o;
  logic       RegWrite_wb_o, MemtoReg_wb_o;
  logic [4:0] rd_wb_o;
`ifdef HAZARD_CNT_EN
  logic [15:0] stall_cnt_o;
`endif

  int   total = 0;
  int   bad   = 0;
  ins_t m_ex, m_mem, m_wb;
  ins_t exp_q[$];
  int   m_cnt;
  int   noop_seen;

  always #5 clk = ~clk;

  ctrl_hazard_pipe dut (
    .clk_i(clk), .rst_i(rst_i),
    .RegWrite_i(RegWrite_i), .MemtoReg_i(MemtoReg_i), .MemRead_i(MemRead_i),
    .MemWrite_i(MemWrite_i), .ALUSrc_i(ALUSrc_i), .ALUOp_i(ALUOp_i),
    .rs1_i(rs1_i), .rs2_i(rs2_i), .rd_i(rd_i),
    .stall_i(stall_i), .flush_i(flush_i),
    .NoOp_o(NoOp_o), .Stall_o(Stall_o),
    .ALUOp_ex_o(ALUOp_ex_o), .ALUSrc_ex_o(ALUSrc_ex_o), .MemRead_ex_o(MemRead_ex_o),
    .rd_ex_o(rd_ex_o),
    .MemRead_mem_o(MemRead_mem_o), .MemWrite_mem_o(MemWrite_mem_o),
    .RegWrite_mem_o(RegWrite_mem_o), .rd_mem_o(rd_mem_o),
    .RegWrite_wb_o(RegWrite_wb_o), .MemtoReg_wb_o(MemtoReg_wb_o), .rd_wb_o(rd_wb_o)
`ifdef HAZARD_CNT_EN
    , .stall_cnt_o(stall_cnt_o)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic ins_t mk(input logic rw, m2r, mrd, mwr, asrc,
                              input logic [1:0] aop, input logic [4:0] rd);
    ins_t i;
    i = '{rw: rw, m2r: m2r, mrd: mrd, mwr: mwr, asrc: asrc, aop: aop, rd: rd};
    return i;
  endfunction

  task automatic drive(input ins_t ins, input logic [4:0] s1, s2, input logic st, fl);
    RegWrite_i = ins.rw;   MemtoReg_i = ins.m2r; MemRead_i = ins.mrd;
    MemWrite_i = ins.mwr;  ALUSrc_i   = ins.asrc; ALUOp_i  = ins.aop;
    rd_i = ins.rd; rs1_i = s1; rs2_i = s2; stall_i = st; flush_i = fl;
  endtask

  // One clock: check the combinational hazard, update the model, check all stages.
  task automatic cyc(input ins_t ins, input logic [4:0] s1, s2, input logic st, fl);
    ins_t e;
    logic hz;
    @(negedge clk);
    rst_i = 1'b0;
    drive(ins, s1, s2, st, fl);
    #1;
    hz = m_ex.mrd && (m_ex.rd != 5'd0) && ((m_ex.rd == s1) || (m_ex.rd == s2));
    check_eq("noop", 32'(NoOp_o), 32'(hz));
    check_eq("stall_o", 32'(Stall_o), 32'(hz));
    if (NoOp_o === 1'b1) noop_seen++;
    if (!st) begin
      m_wb  = mk(m_mem.rw, m_mem.m2r, 1'b0, 1'b0, 1'b0, 2'b00, m_mem.rd);
      m_mem = mk(m_ex.rw, m_ex.m2r, m_ex.mrd, m_ex.mwr, 1'b0, 2'b00, m_ex.rd);
      m_ex  = (fl || hz) ? ins_t'(12'h000) : ins;
      if (hz && m_cnt != 65535) m_cnt++;
    end
    exp_q.push_back(m_ex);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check_eq("queue_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check_eq("ex", 32'({ALUOp_ex_o, ALUSrc_ex_o, MemRead_ex_o, rd_ex_o}),
                     32'({e.aop, e.asrc, e.mrd, e.rd}));
    end
    check_eq("mem", 32'({MemRead_mem_o, MemWrite_mem_o, RegWrite_mem_o, rd_mem_o}),
                    32'({m_mem.mrd, m_mem.mwr, m_mem.rw, m_mem.rd}));
    check_eq("wb", 32'({RegWrite_wb_o, MemtoReg_wb_o, rd_wb_o}),
                   32'({m_wb.rw, m_wb.m2r, m_wb.rd}));
`ifdef HAZARD_CNT_EN
    check_eq("cnt", 32'(stall_cnt_o), 32'(m_cnt));
`endif
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst_i = 1'b1;
    drive(mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'b11, 5'd7), 5'd7, 5'd7, 1'b1, 1'b1);
    repeat (n) @(posedge clk);
    #1;
    check_eq("rst_outs", 32'({ALUOp_ex_o, ALUSrc_ex_o, MemRead_ex_o, rd_ex_o,
                              MemRead_mem_o, MemWrite_mem_o, RegWrite_mem_o, rd_mem_o,
                              RegWrite_wb_o, MemtoReg_wb_o, rd_wb_o}), 32'd0);
    check_eq("rst_noop", 32'({NoOp_o, Stall_o}), 32'd0);
`ifdef HAZARD_CNT_EN
    check_eq("rst_cnt", 32'(stall_cnt_o), 32'd0);
`endif
    m_ex = '0; m_mem = '0; m_wb = '0; m_cnt = 0;
    exp_q.delete();
  endtask

  initial begin
    ins_t nop, rtype, lw3, lw0, add3, add0, sw;
    nop   = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 5'd0);
    rtype = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 5'd5);
    lw3   = mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 5'd3);
    lw0   = mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 5'd0);
    add3  = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 5'd9);
    add0  = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 5'd10);
    sw    = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 5'd0);
    m_cnt = 0;

    do_reset(2);

    // R-type flow through all three stages
    cyc(rtype, 5'd1, 5'd2, 1'b0, 1'b0);
    check_eq("rt_ex_aluop", 32'(ALUOp_ex_o), 32'd2);
    cyc(nop, 5'd0, 5'd0, 1'b0, 1'b0);
    check_eq("rt_mem", 32'({RegWrite_mem_o, rd_mem_o}), 32'({1'b1, 5'd5}));
    cyc(nop, 5'd0, 5'd0, 1'b0, 1'b0);
    check_eq("rt_wb", 32'({RegWrite_wb_o, rd_wb_o}), 32'({1'b1, 5'd5}));

    // Load-use: one bubble, then the dependent add reaches EX
    noop_seen = 0;
    cyc(lw3, 5'd1, 5'd2, 1'b0, 1'b0);
    cyc(add3, 5'd3, 5'd4, 1'b0, 1'b0);
    check_eq("lu_bubble_ex", 32'({MemRead_ex_o, rd_ex_o, ALUOp_ex_o}), 32'd0);
    cyc(add3, 5'd3, 5'd4, 1'b0, 1'b0);
    check_eq("lu_add_ex", 32'({ALUOp_ex_o, rd_ex_o}), 32'({2'b10, 5'd9}));
    check_eq("lu_noop_cycles", 32'(noop_seen), 32'd1);

    // Load to x0 never stalls
    noop_seen = 0;
    cyc(lw0, 5'd1, 5'd2, 1'b0, 1'b0);
    cyc(add0, 5'd0, 5'd0, 1'b0, 1'b0);
    cyc(nop, 5'd0, 5'd0, 1'b0, 1'b0);
    check_eq("x0_noop_cycles", 32'(noop_seen), 32'd0);

    // Stall beats flush: a store in MEM stays put for three cycles
    cyc(sw, 5'd1, 5'd2, 1'b0, 1'b0);
    cyc(lw3, 5'd0, 5'd0, 1'b0, 1'b0);
    repeat (3) begin
      cyc(rtype, 5'd3, 5'd3, 1'b1, 1'b1);
      check_eq("hold_memwrite", 32'(MemWrite_mem_o), 32'd1);
    end
    cyc(nop, 5'd0, 5'd0, 1'b0, 1'b1);

    // Reset mid-stream discards everything in flight
    cyc(rtype, 5'd1, 5'd2, 1'b0, 1'b0);
    cyc(lw3, 5'd1, 5'd2, 1'b0, 1'b0);
    do_reset(1);
    cyc(rtype, 5'd1, 5'd2, 1'b0, 1'b0);
    check_eq("post_rst_ex", 32'({ALUOp_ex_o, rd_ex_o}), 32'({2'b10, 5'd5}));

    // Random mix; loads target a small register set to provoke hazards
    for (int i = 0; i < 60; i++) begin
      ins_t r;
      r = ins_t'($urandom_range(0, 4095));
      r.rd = 5'($urandom_range(0, 3));
      cyc(r, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
          ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
    end

`ifdef HAZARD_CNT_EN
    do_reset(1);
    for (int i = 0; i < 4; i++) begin
      cyc(lw3, 5'd0, 5'd0, 1'b0, 1'b0);
      cyc(add3, 5'd0, 5'd3, 1'b0, 1'b0);
      cyc(add3, 5'd0, 5'd3, 1'b0, 1'b0);
    end
    check_eq("cnt_four", 32'(stall_cnt_o), 32'd4);
    @(negedge clk);
    dut.stall_cnt_r = 16'hFFFD;
    m_cnt = 65533;
    for (int i = 0; i < 4; i++) begin
      cyc(lw3, 5'd0, 5'd0, 1'b0, 1'b0);
      cyc(add3, 5'd3, 5'd0, 1'b0, 1'b0);
      cyc(add3, 5'd3, 5'd0, 1'b0, 1'b0);
    end
    check_eq("cnt_sat", 32'(stall_cnt_o), 32'h0000FFFF);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
